i_execute: RTL and testbench



---
 rtl/i_execute_pkg.sv | 28 ++
 rtl/i_execute_alu.sv | 29 ++
 rtl/i_execute.sv | 117 +++++++++++
 tb/tb_i_execute.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/i_execute_pkg.sv
// Shared encodings for the execute stage: ALUOp values, R-type funct codes
// and the 4-bit ALU operation codes driven into the ALU.
package i_execute_pkg;

  typedef enum logic [1:0] {
    AluopAdd   = 2'b00,
    AluopSub   = 2'b01,
    AluopRtype = 2'b10,
    AluopRsvd  = 2'b11
  } aluop_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // AluZero is not a real operation: it forces a zero result for undefined encodings.
  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSub  = 4'b0110,
    AluSlt  = 4'b0111,
    AluZero = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/i_execute_alu.sv
// Combinational 32-bit ALU with zero flag for the execute stage.
module i_execute_alu
  import i_execute_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic [31:0] w_result;

  always_comb begin
    w_result = 32'd0;
    case (i_op)
      AluAnd:  w_result = i_a & i_b;
      AluOr:   w_result = i_a | i_b;
      AluAdd:  w_result = i_a + i_b;
      AluSub:  w_result = i_a - i_b;
      AluSlt:  w_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
      default: w_result = 32'd0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == 32'd0);

endmodule

// File: rtl/i_execute.sv
// Execute stage: ALU control, operand/destination muxes, branch-target adder
// and the EX/MEM pipeline register with flush and stall.
module i_execute
  import i_execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npcout,
  input  logic [31:0] rdata1out,
  input  logic [31:0] rdata2out,
  input  logic [31:0] s_extendout,
  input  logic [4:0]  instrout_2016,
  input  logic [4:0]  instrout_1511,
  output logic [1:0]  ex_mem_wb,
  output logic        ex_mem_branch,
  output logic        ex_mem_memread,
  output logic        ex_mem_memwrite,
  output logic [31:0] ex_mem_add_result,
  output logic        ex_mem_zero,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_rdata2,
  output logic [4:0]  ex_mem_muxout
);

  alu_op_e     w_alu_op;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic [31:0] w_add_result;
  logic [4:0]  w_muxout;

  logic [1:0]  r_wb;
  logic        r_branch;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_add_result;
  logic        r_zero;
  logic [31:0] r_alu_result;
  logic [31:0] r_rdata2;
  logic [4:0]  r_muxout;

  always_comb begin
    w_alu_op = AluZero;
    unique case (aluop)
      AluopAdd: w_alu_op = AluAdd;
      AluopSub: w_alu_op = AluSub;
      AluopRtype: begin
        case (s_extendout[5:0])
          FunctAdd: w_alu_op = AluAdd;
          FunctSub: w_alu_op = AluSub;
          FunctAnd: w_alu_op = AluAnd;
          FunctOr:  w_alu_op = AluOr;
          FunctSlt: w_alu_op = AluSlt;
          default:  w_alu_op = AluZero;
        endcase
      end
      AluopRsvd: w_alu_op = AluZero;
      default:   w_alu_op = AluZero;
    endcase
  end

  assign w_alu_b      = alusrc ? s_extendout : rdata2out;
  assign w_muxout     = regdst ? instrout_1511 : instrout_2016;
  // Shift inside a 32-bit context so the top two immediate bits fall off.
  assign w_add_result = npcout + (s_extendout << 2);

  i_execute_alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (rdata1out),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_zero   (w_zero)
  );

  // Flush bubbles only the control bits; data still loads so the slot is well defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb         <= 2'b00;
      r_branch     <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_add_result <= 32'd0;
      r_zero       <= 1'b0;
      r_alu_result <= 32'd0;
      r_rdata2     <= 32'd0;
      r_muxout     <= 5'd0;
    end else if (flush || !stall) begin
      r_wb         <= flush ? 2'b00 : wb_ctlout;
      r_branch     <= flush ? 1'b0 : m_ctlout[2];
      r_memread    <= flush ? 1'b0 : m_ctlout[1];
      r_memwrite   <= flush ? 1'b0 : m_ctlout[0];
      r_add_result <= w_add_result;
      r_zero       <= w_zero;
      r_alu_result <= w_alu_result;
      r_rdata2     <= rdata2out;
      r_muxout     <= w_muxout;
    end
  end

  assign ex_mem_wb         = r_wb;
  assign ex_mem_branch     = r_branch;
  assign ex_mem_memread    = r_memread;
  assign ex_mem_memwrite   = r_memwrite;
  assign ex_mem_add_result = r_add_result;
  assign ex_mem_zero       = r_zero;
  assign ex_mem_alu_result = r_alu_result;
  assign ex_mem_rdata2     = r_rdata2;
  assign ex_mem_muxout     = r_muxout;

endmodule

// File: tb/tb_i_execute.sv
// Scoreboard bench for i_execute: a driver pushes hand-computed EX/MEM values,
// a monitor pops one entry per rising edge and compares.
module tb_i_execute;

  typedef struct packed {
    logic [1:0]  wb;
    logic        br;
    logic        mr;
    logic        mw;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  mux;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic        regdst, alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
  logic [4:0]  instrout_2016, instrout_1511;
  logic [1:0]  ex_mem_wb;
  logic        ex_mem_branch, ex_mem_memread, ex_mem_memwrite;
  logic [31:0] ex_mem_add_result;
  logic        ex_mem_zero;
  logic [31:0] ex_mem_alu_result, ex_mem_rdata2;
  logic [4:0]  ex_mem_muxout;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q_exp[$];
  string q_name[$];
  exp_t last_exp = '0;

  always #5 clk = ~clk;

  i_execute dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .wb_ctlout         (wb_ctlout),
    .m_ctlout          (m_ctlout),
    .regdst            (regdst),
    .alusrc            (alusrc),
    .aluop             (aluop),
    .npcout            (npcout),
    .rdata1out         (rdata1out),
    .rdata2out         (rdata2out),
    .s_extendout       (s_extendout),
    .instrout_2016     (instrout_2016),
    .instrout_1511     (instrout_1511),
    .ex_mem_wb         (ex_mem_wb),
    .ex_mem_branch     (ex_mem_branch),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_add_result (ex_mem_add_result),
    .ex_mem_zero       (ex_mem_zero),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rdata2     (ex_mem_rdata2),
    .ex_mem_muxout     (ex_mem_muxout)
  );

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = {ex_mem_wb, ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_add_result,
         ex_mem_zero, ex_mem_alu_result, ex_mem_rdata2, ex_mem_muxout};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got wb=%b m=%b%b%b add=%h z=%b alu=%h rd2=%h mux=%0d | want wb=%b m=%b%b%b add=%h z=%b alu=%h rd2=%h mux=%0d",
               name, a.wb, a.br, a.mr, a.mw, a.add, a.zero, a.alu, a.rd2, a.mux,
               e.wb, e.br, e.mr, e.mw, e.add, e.zero, e.alu, e.rd2, e.mux);
    end
  endtask

  // Drive one cycle of inputs and push what EX/MEM must hold after the next edge.
  task automatic issue(input string name, input logic st, input logic fl,
                       input logic [1:0] wb, input logic [2:0] m, input logic rdst,
                       input logic asrc, input logic [1:0] aop, input logic [31:0] npc,
                       input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] x_add, input logic x_zero,
                       input logic [31:0] x_alu, input logic [4:0] x_mux);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; wb_ctlout = wb; m_ctlout = m; regdst = rdst; alusrc = asrc;
    aluop = aop; npcout = npc; rdata1out = a; rdata2out = b2; s_extendout = imm;
    instrout_2016 = rt; instrout_1511 = rd;
    if (st && !fl) begin
      e = last_exp;
    end else begin
      e.wb = fl ? 2'b00 : wb;
      {e.br, e.mr, e.mw} = fl ? 3'b000 : m;
      e.add = x_add; e.zero = x_zero; e.alu = x_alu; e.rd2 = b2; e.mux = x_mux;
    end
    last_exp = e;
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_exp.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q_exp.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q_exp.size());
      q_exp.delete();
      q_name.delete();
    end
  endtask

  initial begin
    exp_t e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        check(nm, e);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_ctlout = '0; m_ctlout = '0; regdst = 1'b0;
    alusrc = 1'b0; aluop = '0; npcout = '0; rdata1out = '0; rdata2out = '0;
    s_extendout = '0; instrout_2016 = '0; instrout_1511 = '0;
    #12;
    check("reset_state", '0);
    rst = 1'b0;

    //    name          st fl wb    m       rd as aop   npc           A             B/rdata2      imm           rt rd  add           z  alu           mux
    issue("rtype_add", 0, 0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0,        32'd5,        32'd7,        32'h20,       5, 3,  32'h80,       0, 32'd12,       3);
    issue("sub_zero",  0, 0, 2'b01, 3'b010, 0, 0, 2'b01, 32'h100,      32'h1234,     32'h1234,     32'hFFFFFFFF, 9, 4,  32'hFC,       1, 32'd0,        9);
    issue("slt_neg",   0, 0, 2'b11, 3'b001, 1, 0, 2'b10, 32'h4,        32'hFFFFFFFF, 32'd1,        32'h2A,       0, 31, 32'hAC,       0, 32'd1,        31);
    issue("sub_wrap",  0, 0, 2'b00, 3'b100, 0, 1, 2'b01, 32'h10,       32'd0,        32'hDEAD,     32'd1,        7, 6,  32'h14,       0, 32'hFFFFFFFF, 7);
    issue("and",       0, 0, 2'b10, 3'b000, 1, 0, 2'b10, 32'h0,        32'hF0F0FF00, 32'h0FF0F0F0, 32'h24,       1, 8,  32'h90,       0, 32'h00F0F000, 8);
    issue("or",        0, 0, 2'b10, 3'b000, 0, 0, 2'b10, 32'h0,        32'hF0000000, 32'h0000000F, 32'h25,       2, 8,  32'h94,       0, 32'hF000000F, 2);
    issue("add_wrap",  0, 0, 2'b01, 3'b000, 0, 1, 2'b00, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd5,        32'd1,        1, 9,  32'h0,        1, 32'd0,        1);
    issue("bad_funct", 0, 0, 2'b10, 3'b000, 0, 0, 2'b10, 32'h0,        32'd3,        32'd4,        32'h3F,       4, 9,  32'hFC,       1, 32'd0,        4);
    issue("aluop_11",  0, 0, 2'b10, 3'b000, 0, 1, 2'b11, 32'h0,        32'd1,        32'd0,        32'd2,        5, 9,  32'h8,        1, 32'd0,        5);
    issue("slt_pos",   0, 0, 2'b10, 3'b000, 0, 0, 2'b10, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h2A,       6, 9,  32'hA8,       1, 32'd0,        6);
    // Load a reference value, then stall three cycles with unrelated inputs.
    issue("pre_stall", 0, 0, 2'b11, 3'b101, 1, 0, 2'b10, 32'h0,        32'd5,        32'd7,        32'h20,       5, 3,  32'h80,       0, 32'd12,       3);
    issue("stall_1",   1, 0, 2'b00, 3'b010, 0, 1, 2'b01, 32'h40,       32'd99,       32'd1,        32'd9,        2, 4,  32'h0,        0, 32'd0,        0);
    issue("stall_2",   1, 0, 2'b01, 3'b111, 1, 0, 2'b00, 32'h80,       32'd0,        32'd0,        32'd0,        0, 0,  32'h0,        0, 32'd0,        0);
    issue("stall_3",   1, 0, 2'b10, 3'b000, 0, 0, 2'b10, 32'hC0,       32'd1,        32'd2,        32'h25,       7, 1,  32'h0,        0, 32'd0,        0);
    issue("flush_stl", 1, 1, 2'b11, 3'b111, 1, 0, 2'b00, 32'h20,       32'd2,        32'd3,        32'd1,        4, 12, 32'h24,       0, 32'd5,        12);
    issue("hold_fl",   1, 0, 2'b11, 3'b111, 0, 0, 2'b00, 32'h0,        32'd8,        32'd8,        32'd0,        1, 2,  32'h0,        0, 32'd0,        0);
    issue("flush",     0, 1, 2'b01, 3'b110, 0, 1, 2'b01, 32'h0,        32'd9,        32'd3,        32'd9,        11, 2, 32'h24,       1, 32'd0,        11);
    issue("resume",    0, 0, 2'b01, 3'b110, 0, 1, 2'b01, 32'h0,        32'd10,       32'd3,        32'd9,        11, 2, 32'h24,       0, 32'd1,        11);
    drain();

    // Asynchronous reset between edges with nonzero outputs.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", '0);
    @(posedge clk);
    #1;
    check("rst_held", '0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;
    issue("after_rst", 0, 0, 2'b10, 3'b010, 1, 0, 2'b10, 32'h8,        32'd5,        32'd7,        32'h20,       5, 3,  32'h88,       0, 32'd12,       3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
